// File: rtl/multi_edge_detector_if.sv
// multi_edge_detector_if: channel bus between raw pin taps and the multi-channel edge detector
interface multi_edge_detector_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0]   sig_in;
    logic [2*NUM_CH-1:0] mode;
    logic [NUM_CH-1:0]   sticky_clr;
    logic [NUM_CH-1:0]   level;
    logic [NUM_CH-1:0]   rise;
    logic [NUM_CH-1:0]   fall;
    logic [NUM_CH-1:0]   edge_sig;
    logic [NUM_CH-1:0]   sticky;

    modport master (
        output sig_in, mode, sticky_clr,
        input  level, rise, fall, edge_sig, sticky
    );

    modport slave (
        input  sig_in, mode, sticky_clr,
        output level, rise, fall, edge_sig, sticky
    );
endinterface

// File: rtl/multi_edge_detector.sv
// multi_edge_detector: per-channel sync + debounce with rise/fall/selected-edge pulses; MULTI_EDGE_DET_STICKY_EN adds latched edge flags
module multi_edge_detector #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter bit RESET_LEVEL = 1'b0
) (
    input logic sys_clk,
    input logic rst_n,
    multi_edge_detector_if.slave bus
);
    localparam int CNT_W = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync [NUM_CH];
    logic [CNT_W-1:0]       cnt  [NUM_CH];
    logic [NUM_CH-1:0]      s_q, flip, rise_sel, fall_sel;
    logic [NUM_CH-1:0]      level_q, rise_q, fall_q, edge_q;

    // decode synchroniser outputs, flip condition and per-channel edge selects
    always_comb begin
        s_q      = '0;
        flip     = '0;
        rise_sel = '0;
        fall_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            s_q[c]      = sync[c][SYNC_STAGES-1];
            flip[c]     = (sync[c][SYNC_STAGES-1] != level_q[c]) && (cnt[c] == CNT_LAST);
            rise_sel[c] = bus.mode[2*c];
            fall_sel[c] = bus.mode[2*c+1];
        end
    end

    // synchroniser shift chains, one per channel
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) sync[c] <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            for (int c = 0; c < NUM_CH; c++) sync[c] <= {sync[c][SYNC_STAGES-2:0], bus.sig_in[c]};
        end
    end

    // stability counters; any agreement with the current level discards the pending count
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
            level_q <= {NUM_CH{RESET_LEVEL}};
        end else begin
            for (int c = 0; c < NUM_CH; c++) cnt[c] <= (s_q[c] == level_q[c] || flip[c]) ? '0 : cnt[c] + 1'b1;
            level_q <= level_q ^ flip;
        end
    end

    // one-cycle pulses registered on the flipping edge, mode sampled on that same edge
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= '0;
            fall_q <= '0;
            edge_q <= '0;
        end else begin
            rise_q <= flip & s_q;
            fall_q <= flip & ~s_q;
            edge_q <= flip & ((s_q & rise_sel) | (~s_q & fall_sel));
        end
    end

    assign bus.level    = level_q;
    assign bus.rise     = rise_q;
    assign bus.fall     = fall_q;
    assign bus.edge_sig = edge_q;

`ifdef MULTI_EDGE_DET_STICKY_EN
    logic [NUM_CH-1:0] sticky_q;

    // latch each reported edge until cleared; a new edge beats a coincident clear
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) sticky_q <= '0;
        else        sticky_q <= edge_q | (sticky_q & ~bus.sticky_clr);
    end

    assign bus.sticky = sticky_q;
`else
    logic unused_clr;

    assign unused_clr = ^bus.sticky_clr;
    assign bus.sticky = '0;
`endif
endmodule

// File: tb/tb_multi_edge_detector.sv
// tb_multi_edge_detector: randomized and directed checks against a sliding-window reference model
module tb_multi_edge_detector;
    localparam int N = 4;
    localparam int S = 2;
    localparam int F = 4;
`ifdef MULTI_EDGE_DET_STICKY_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic sys_clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 sys_clk = ~sys_clk;

    multi_edge_detector_if #(.NUM_CH(N)) bus ();

    multi_edge_detector #(
        .NUM_CH(N), .SYNC_STAGES(S), .FILTER_LEN(F), .RESET_LEVEL(1'b0)
    ) dut (
        .sys_clk(sys_clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // reference: history of sampled inputs, newest at bit 0
    logic [S+F-1:0] hist [N];
    logic [N-1:0]   m_level, m_rise, m_fall, m_edge, m_sticky;

    function automatic logic [5*N-1:0] obs();
        return {bus.level, bus.rise, bus.fall, bus.edge_sig, bus.sticky};
    endfunction

    function automatic logic [5*N-1:0] expv();
        return {m_level, m_rise, m_fall, m_edge, m_sticky};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N; c++) hist[c] = '0;
        m_level = '0; m_rise = '0; m_fall = '0; m_edge = '0; m_sticky = '0;
    endtask

    // one clock: the level flips once the F most recent synchronised samples all disagree with it
    task automatic step();
        bit all_diff;
        @(posedge sys_clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (STK) m_sticky = m_edge | (m_sticky & ~bus.sticky_clr);
            for (int c = 0; c < N; c++) begin
                hist[c] = {hist[c][S+F-2:0], bus.sig_in[c]};
                all_diff = 1'b1;
                for (int k = S; k < S + F; k++) if (hist[c][k] == m_level[c]) all_diff = 1'b0;
                m_rise[c] = all_diff & ~m_level[c];
                m_fall[c] = all_diff & m_level[c];
                m_edge[c] = (m_rise[c] & bus.mode[2*c]) | (m_fall[c] & bus.mode[2*c+1]);
                if (all_diff) m_level[c] = ~m_level[c];
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.sig_in = '0; bus.mode = '0; bus.sticky_clr = '0;
        model_reset();
        repeat (3) step();
        n_tests++;
        if (obs() !== '0) begin n_fail++; $display("FAIL reset_state got=%h exp=0", obs()); end
        rst_n = 1'b1;
        repeat (4) begin
            step();
            n_tests++;
            if (obs() !== expv()) begin n_fail++; $display("FAIL reset_idle got=%h exp=%h", obs(), expv()); end
        end
    endtask

    task automatic test_rise();
        int lat = 0;
        bus.mode = 8'b00_00_00_01;
        bus.sig_in[0] = 1'b1;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            step();
            n_tests++;
            if (obs() !== expv()) begin n_fail++; $display("FAIL rise_model got=%h exp=%h", obs(), expv()); end
            if (bus.level[0]) begin
                lat = k;
                n_tests++;
                if ({bus.rise[0], bus.edge_sig[0], bus.fall[0]} !== 3'b110) begin
                    n_fail++; $display("FAIL rise_pulse got=%b exp=110", {bus.rise[0], bus.edge_sig[0], bus.fall[0]});
                end
            end
        end
        n_tests++;
        if (lat != S + F) begin n_fail++; $display("FAIL rise_latency got=%0d exp=%0d", lat, S + F); end
        step();
        n_tests++;
        if ({bus.rise[0], bus.edge_sig[0]} !== 2'b00) begin n_fail++; $display("FAIL rise_one_cycle got=%b exp=00", {bus.rise[0], bus.edge_sig[0]}); end
    endtask

    task automatic test_glitch();
        int n_rise = 0, n_fall = 0;
        bus.mode = 8'b00_00_11_01;
        bus.sig_in[1] = 1'b1;
        for (int k = 0; k < 14; k++) begin
            if (k == 3) bus.sig_in[1] = 1'b0;
            step();
            n_tests++;
            if ({bus.level[1], bus.rise[1], bus.fall[1], bus.edge_sig[1]} !== 4'b0000 || obs() !== expv()) begin
                n_fail++; $display("FAIL glitch_reject got=%h exp=%h", obs(), expv());
            end
        end
        bus.sig_in[1] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k == 4) bus.sig_in[1] = 1'b0;
            step();
            n_rise += bus.rise[1];
            n_fall += bus.fall[1];
            n_tests++;
            if (obs() !== expv()) begin n_fail++; $display("FAIL pulse4_model got=%h exp=%h", obs(), expv()); end
        end
        n_tests++;
        if (n_rise != 1 || n_fall != 1) begin n_fail++; $display("FAIL pulse4_count got=%0d/%0d exp=1/1", n_rise, n_fall); end
    endtask

    task automatic test_mode();
        int n_rise, n_fall, n_edge;
        bus.mode = 8'b00_10_00_01;
        for (int ph = 0; ph < 3; ph++) begin
            n_rise = 0; n_fall = 0; n_edge = 0;
            bus.sig_in[2] = (ph != 1);
            for (int k = 0; k < 10; k++) begin
                if (ph == 2 && k == 3) bus.mode[5:4] = 2'b00;
                step();
                n_rise += bus.rise[2]; n_fall += bus.fall[2]; n_edge += bus.edge_sig[2];
                n_tests++;
                if (obs() !== expv()) begin n_fail++; $display("FAIL mode_model got=%h exp=%h", obs(), expv()); end
            end
            n_tests++;
            if (n_rise != (ph != 1) || n_fall != (ph == 1) || n_edge != (ph == 1)) begin
                n_fail++; $display("FAIL mode_phase%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", ph, n_rise, n_fall, n_edge,
                                   ph != 1, ph == 1, ph == 1);
            end
        end
    endtask

    task automatic test_simultaneous();
        int lat = 0;
        bus.mode = 8'hFF;
        bus.sig_in = ~bus.sig_in;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            step();
            n_tests++;
            if (obs() !== expv()) begin n_fail++; $display("FAIL simul_model got=%h exp=%h", obs(), expv()); end
            if (bus.edge_sig != '0) begin
                lat = k;
                n_tests++;
                if (bus.edge_sig !== 4'b1111) begin n_fail++; $display("FAIL simul_edges got=%b exp=1111", bus.edge_sig); end
            end
        end
        n_tests++;
        if (lat != S + F) begin n_fail++; $display("FAIL simul_latency got=%0d exp=%0d", lat, S + F); end
    endtask

    task automatic test_reset_mid();
        int lat = 0;
        bus.sig_in = '0;
        bus.mode = 8'b01_00_00_00;
        repeat (10) step();
        bus.sig_in[3] = 1'b1;
        repeat (2) step();
        rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (obs() !== '0) begin n_fail++; $display("FAIL reset_mid_async got=%h exp=0", obs()); end
        repeat (2) step();
        rst_n = 1'b1;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            step();
            n_tests++;
            if (obs() !== expv()) begin n_fail++; $display("FAIL reset_mid_model got=%h exp=%h", obs(), expv()); end
            if (bus.level[3]) lat = k;
        end
        n_tests++;
        if (lat != S + F) begin n_fail++; $display("FAIL reset_release_latency got=%0d exp=%0d", lat, S + F); end
    endtask

    task automatic test_sticky();
        bit seen = 1'b0;
        step();
        n_tests++;
        if (bus.sticky[3] !== STK) begin n_fail++; $display("FAIL sticky_set got=%b exp=%b", bus.sticky[3], STK); end
        bus.mode = 8'b11_00_00_00;
        bus.sig_in[3] = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            seen = bus.edge_sig[3];
        end
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL sticky_edge_wait got=0 exp=1"); end
        bus.sticky_clr = 4'b1000;
        step();
        n_tests++;
        if (bus.sticky[3] !== STK || obs() !== expv()) begin n_fail++; $display("FAIL sticky_set_wins got=%h exp=%h", obs(), expv()); end
        step();
        n_tests++;
        if (bus.sticky[3] !== 1'b0 || obs() !== expv()) begin n_fail++; $display("FAIL sticky_clear got=%h exp=%h", obs(), expv()); end
        bus.sticky_clr = '0;
        step();
        n_tests++;
        if (bus.sticky[3] !== 1'b0) begin n_fail++; $display("FAIL sticky_clear_hold got=%b exp=0", bus.sticky[3]); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            for (int c = 0; c < N; c++) if ($urandom_range(0, 5) == 0) bus.sig_in[c] = ~bus.sig_in[c];
            if ($urandom_range(0, 15) == 0) bus.mode = 8'($urandom);
            bus.sticky_clr = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                n_tests++;
                if (obs() !== '0) begin n_fail++; $display("FAIL rand_async_reset got=%h exp=0", obs()); end
                step();
                rst_n = 1'b1;
            end
            step();
            n_tests++;
            if (obs() !== expv()) begin n_fail++; $display("FAIL rand_model step=%0d got=%h exp=%h", k, obs(), expv()); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_rise();
        test_glitch();
        test_mode();
        test_simultaneous();
        test_reset_mid();
        test_sticky();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multi_edge_detector.md
Name: multi_edge_detector

Overview:
- Multi-channel successor to the single-line edge detector.
- Accepts NUM_CH asynchronous inputs and synchronises each into sys_clk.
- Debounces each channel with a per-channel stability counter, then reports filtered level and one-cycle rise/fall/selected-edge pulses.
- Sits between raw bus/pin taps and the protocol decoders; removes the requirement that inputs already be synchronous and glitch-free.

Parameters:
- NUM_CH, 4, number of independent channels (>=1).
- SYNC_STAGES, 2, synchroniser flop depth per channel (>=2).
- FILTER_LEN, 4, consecutive synchronised samples that must differ from the current level before it flips (>=1; 1 = no filtering).
- RESET_LEVEL, 0, value loaded into synchroniser flops and filtered level on reset (0 or 1).
- CNT_W is derived internally as clog2(FILTER_LEN+1); it is not user-settable.

Ports:
- sys_clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sig_in  input  NUM_CH  raw asynchronous channel inputs.
- mode  input  2*NUM_CH  per-channel edge select, bits [2i+1:2i]: 00 none, 01 rise, 10 fall, 11 both.
- level  output  NUM_CH  debounced, synchronised level.
- rise  output  NUM_CH  one-cycle pulse on filtered 0->1.
- fall  output  NUM_CH  one-cycle pulse on filtered 1->0.
- edge_sig  output  NUM_CH  one-cycle pulse on edge selected by mode.
- sticky  output  NUM_CH  latched edge flag (optional feature).
- sticky_clr  input  NUM_CH  per-channel sticky clear, synchronous.

Behaviour:
- Reset: while rst_n=0, asynchronously force the following; hold until the first sys_clk edge after release.
  - Sync flops and level = RESET_LEVEL on all channels.
  - Counters = 0.
  - rise, fall, edge_sig, sticky = 0.
- Reset mid-operation: pending counts are discarded and no pulse is emitted.
- Synchroniser: plain SYNC_STAGES shift chain per channel; the last stage is s_q.
- Filter, per channel, every edge:
  - s_q == level: cnt <= 0.
  - s_q != level and cnt < FILTER_LEN-1: cnt <= cnt+1.
  - s_q != level and cnt == FILTER_LEN-1: level <= s_q, cnt <= 0.
- Latency: for an input change held stable, level flips SYNC_STAGES+FILTER_LEN edges after the first edge that samples it. Defaults: 6 cycles.
- Glitch rejection: any return of s_q to level before the count completes resets cnt. A glitch shorter than FILTER_LEN synchronised cycles produces no output.
- Pulses: registered and asserted in the same cycle level flips, high for exactly one cycle.
  - rise = flip to 1; fall = flip to 0.
  - edge_sig = (rise & mode[0]) | (fall & mode[1]), evaluated with mode as sampled on the flipping edge.
  - Mode changes affect only later flips. No retroactive pulse.
- Spacing: consecutive pulses on one channel are at least FILTER_LEN cycles apart. rise and fall are never simultaneous on one channel.
- Channels are fully independent. Simultaneous edges on several channels each pulse in their own bit.
- Release from reset with sig_in != RESET_LEVEL: this is a genuine edge and is reported after normal latency.
- Outputs never glitch combinationally; all outputs are flop-driven.

Optional Feature:
- Macro: MULTI_EDGE_DET_STICKY_EN.
- With macro defined:
  - sticky[i] sets on the edge after edge_sig[i]=1 and holds until sticky_clr[i]=1.
  - Clear takes effect on the next edge.
  - Simultaneous new edge_sig and clear: set wins, sticky stays 1.
  - sticky_clr while sticky=0 has no effect.
- Without macro: sticky is driven constant 0, sticky_clr is ignored, and no sticky flops are synthesised. Ports remain for interface stability.

Test Plan:
- Defaults, ch0 mode=01. sig_in[0] 0->1 held. -> level[0] rises 6 cycles later; rise[0]=edge_sig[0]=1 for exactly that cycle; fall[0] stays 0.
- sig_in[1] high for 3 cycles then low, mode=11. -> level[1], rise, fall, edge_sig stay 0 throughout; then 4-cycle pulse -> rise then fall, each one cycle.
- ch2 mode=10, toggle 0->1->0 with 10-cycle holds. -> rise[2] pulses, edge_sig[2] only on fall; switch mode to 00 mid-hold -> next flip gives rise/fall but no edge_sig.
- All 4 channels toggle same cycle, mode=11. -> edge_sig=4'b1111 on one cycle, 6 cycles after toggle.
- rst_n pulled low 2 cycles after a change (count pending). -> outputs 0 immediately. After release with input still high -> edge reported 6 cycles after release.
- STICKY_EN: edge on ch3 -> sticky[3]=1 stays; sticky_clr[3] asserted coincident with a new edge_sig[3] -> sticky stays 1; clear alone -> 0 next cycle.
